ttc_capture_lite2: RTL and testbench

//  Input-capture companion to the TTC counter: measures an external waveform
//  (e.g. another timer's waveform output) instead of generating one.

---
 rtl/ttc_capture_lite2.sv | 145 ++++++++++++++
 tb/tb_ttc_capture_lite2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_capture_lite2.sv
// ttc_capture_lite2: input-capture companion to the TTC counter. Measures the
// period and active-phase width of an external waveform in prescaler ticks.
module ttc_capture_lite2 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        pclk2,
   input  logic        p_reset2,
   input  logic [15:0] pwdata2,
   input  logic        count_en2,
   input  logic        cap_ctrl_reg_sel2,
   input  logic        cap_rd2,
   input  logic        ext_wave_in2,
   output logic [3:0]  cap_ctrl_reg_out2,
   output logic [15:0] period_reg_out2,
   output logic [15:0] active_reg_out2,
   output logic        cap_valid2,
   output logic        capture_intr2,
   output logic        overrun_intr2,
   output logic        timeout_intr2
);

   typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

   state_t                 state, state_nxt;
   logic [3:0]             ctrl;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise, fall, start_edge, end_edge;
   logic [15:0]            cnt, cnt_nxt;
   logic [15:0]            period_q, period_nxt;
   logic [15:0]            active_q, active_nxt;
   logic                   capture, timeout;
   logic                   unused_pwdata;

   assign unused_pwdata = ^pwdata2[15:4];

   always_ff @(posedge pclk2) begin
      if (p_reset2) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_wave_in2};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise       = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall       = ~sync_q[SYNC_STAGES-1] & hist_q;
   assign start_edge = ctrl[1] ? fall : rise;
   assign end_edge   = ctrl[1] ? rise : fall;

   // Restart bit lives for exactly one cycle unless rewritten
   always_ff @(posedge pclk2) begin
      if (p_reset2) begin
         ctrl <= 4'b0001;
      end else if (cap_ctrl_reg_sel2) begin
         ctrl <= pwdata2[3:0];
      end else if (ctrl[3]) begin
         ctrl[3] <= 1'b0;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      period_nxt = period_q;
      active_nxt = active_q;
      capture    = 1'b0;
      timeout    = 1'b0;
      if (ctrl[0]) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (ctrl[3]) begin
         state_nxt = ARM;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nxt   = '0;
               state_nxt = ARM;
            end
            ARM: begin
               if (start_edge) begin
                  cnt_nxt   = '0;
                  state_nxt = MEAS;
               end
            end
            MEAS: begin
               // A tick coinciding with the start edge belongs to the new interval
               if (start_edge) begin
                  capture    = 1'b1;
                  period_nxt = cnt;
                  cnt_nxt    = {15'd0, count_en2};
                  if (ctrl[2]) begin
                     state_nxt = DONE;
                  end
               end else if (count_en2 && (cnt == 16'hFFFF)) begin
                  timeout   = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = ARM;
               end else begin
                  if (end_edge) begin
                     active_nxt = cnt;
                  end
                  if (count_en2) begin
                     cnt_nxt = cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk2) begin
      if (p_reset2) begin
         state         <= IDLE;
         cnt           <= '0;
         period_q      <= '0;
         active_q      <= '0;
         cap_valid2    <= 1'b0;
         capture_intr2 <= 1'b0;
         overrun_intr2 <= 1'b0;
         timeout_intr2 <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         period_q      <= period_nxt;
         active_q      <= active_nxt;
         capture_intr2 <= capture;
         overrun_intr2 <= capture & cap_valid2 & ~cap_rd2;
         timeout_intr2 <= timeout;
         if (capture) begin
            cap_valid2 <= 1'b1;
         end else if (cap_rd2) begin
            cap_valid2 <= 1'b0;
         end
      end
   end

   assign cap_ctrl_reg_out2 = ctrl;
   assign period_reg_out2   = period_q;
   assign active_reg_out2   = active_q;

endmodule

// File: tb/tb_ttc_capture_lite2.sv
// Testbench for ttc_capture_lite2: directed scenarios plus randomized traffic,
// checked every cycle against a tick-window reference model.
module tb_ttc_capture_lite2;

   localparam int SYNC = 2;
   localparam int MAXC = 100000;

   logic        pclk2;
   logic        p_reset2;
   logic [15:0] pwdata2;
   logic        count_en2;
   logic        cap_ctrl_reg_sel2;
   logic        cap_rd2;
   logic        ext_wave_in2;
   logic [3:0]  cap_ctrl_reg_out2;
   logic [15:0] period_reg_out2;
   logic [15:0] active_reg_out2;
   logic        cap_valid2;
   logic        capture_intr2;
   logic        overrun_intr2;
   logic        timeout_intr2;

   ttc_capture_lite2 #(.SYNC_STAGES(SYNC)) dut (
      .pclk2             (pclk2),
      .p_reset2          (p_reset2),
      .pwdata2           (pwdata2),
      .count_en2         (count_en2),
      .cap_ctrl_reg_sel2 (cap_ctrl_reg_sel2),
      .cap_rd2           (cap_rd2),
      .ext_wave_in2      (ext_wave_in2),
      .cap_ctrl_reg_out2 (cap_ctrl_reg_out2),
      .period_reg_out2   (period_reg_out2),
      .active_reg_out2   (active_reg_out2),
      .cap_valid2        (cap_valid2),
      .capture_intr2     (capture_intr2),
      .overrun_intr2     (overrun_intr2),
      .timeout_intr2     (timeout_intr2)
   );

   initial pclk2 = 1'b0;
   always #5 pclk2 = ~pclk2;

   int vectors     = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input logic [39:0] got, input logic [39:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: interval values are tick sums over windows of clock edges
   typedef enum int {M_OFF, M_ARMED, M_RUN, M_HELD} mmode_t;
   bit          wv   [0:MAXC-1];
   int          pref [0:MAXC-1];
   int          pe = 8;
   int          win = 1;
   mmode_t      m_mode = M_OFF;
   logic [3:0]  m_ctrl = 4'b0001;
   logic [15:0] m_period = '0, m_active = '0;
   logic        m_valid = 0, m_cap = 0, m_ovr = 0, m_to = 0;

   always @(posedge pclk2) begin
      logic [3:0] c;
      logic       st, en, rise, fall;
      int         cur;
      pe = pe + 1;
      pref[pe] = pref[pe-1] + (count_en2 ? 1 : 0);
      wv[pe]   = ext_wave_in2;
      if (p_reset2) begin
         for (int i = 0; i <= SYNC; i++) wv[pe-i] = 1'b0;
         m_mode = M_OFF; m_ctrl = 4'b0001; m_period = '0; m_active = '0;
         m_valid = 0; m_cap = 0; m_ovr = 0; m_to = 0;
      end else begin
         c    = m_ctrl;
         rise = wv[pe-SYNC] && !wv[pe-SYNC-1];
         fall = !wv[pe-SYNC] && wv[pe-SYNC-1];
         st   = c[1] ? fall : rise;
         en   = c[1] ? rise : fall;
         m_cap = 0;
         m_to  = 0;
         if (c[0]) m_mode = M_OFF;
         else if (c[3]) m_mode = M_ARMED;
         else begin
            case (m_mode)
               M_OFF:   m_mode = M_ARMED;
               M_ARMED: if (st) begin m_mode = M_RUN; win = pe + 1; end
               M_RUN: begin
                  cur = pref[pe-1] - pref[win-1];
                  if (st) begin
                     m_cap = 1; m_period = 16'(cur); win = pe;
                     if (c[2]) m_mode = M_HELD;
                  end else if (count_en2 && cur == 65535) begin
                     m_to = 1; m_mode = M_ARMED;
                  end else if (en) begin
                     m_active = 16'(cur);
                  end
               end
               default: ;
            endcase
         end
         m_ovr = m_cap && m_valid && !cap_rd2;
         if (m_cap) m_valid = 1;
         else if (cap_rd2) m_valid = 0;
         if (cap_ctrl_reg_sel2) m_ctrl = pwdata2[3:0];
         else if (c[3]) m_ctrl[3] = 1'b0;
      end
   end

   bit checking_on = 0;
   int cap_cnt = 0, ovr_cnt = 0, to_cnt = 0, last_to_pe = 0;

   always @(negedge pclk2) begin
      if (checking_on) begin
         checkOutput("cycle",
            {cap_ctrl_reg_out2, cap_valid2, capture_intr2, overrun_intr2, timeout_intr2,
             period_reg_out2, active_reg_out2},
            {m_ctrl, m_valid, m_cap, m_ovr, m_to, m_period, m_active});
         if (capture_intr2) cap_cnt++;
         if (overrun_intr2) ovr_cnt++;
         if (timeout_intr2) begin to_cnt++; last_to_pe = pe; end
      end
   end

   // Stimulus generator state
   int         wave_mode = 0, en_mode = 0, rd_mode = 0;
   int         wcnt = 0, period_len = 100, high_len = 30, seg_left = 0;
   bit         pending_wr = 0, force_rd = 0, rst_req = 0;
   logic [3:0] pending_val = '0;

   task automatic applyStimulus();
      @(negedge pclk2);
      case (wave_mode)
         1: ext_wave_in2 = (wcnt < high_len);
         2: if (seg_left == 0) begin
               ext_wave_in2 = ~ext_wave_in2;
               seg_left = $urandom_range(3, 80);
            end else seg_left--;
         default: ;
      endcase
      case (en_mode)
         1: count_en2 = ((wcnt % 4) == (SYNC % 4));
         2: count_en2 = ($urandom_range(0, 3) != 0);
         default: count_en2 = 1'b1;
      endcase
      case (rd_mode)
         1: cap_rd2 = ($urandom_range(0, 15) == 0);
         2: cap_rd2 = (wcnt == SYNC);
         default: cap_rd2 = 1'b0;
      endcase
      if (force_rd) begin cap_rd2 = 1'b1; force_rd = 0; end
      if (wave_mode == 1) wcnt = (wcnt + 1) % period_len;
      cap_ctrl_reg_sel2 = pending_wr;
      pwdata2 = pending_wr ? {12'($urandom), pending_val} : 16'($urandom);
      pending_wr = 0;
      p_reset2 = rst_req;
   endtask

   task automatic runCycles(input int n);
      repeat (n) applyStimulus();
   endtask

   task automatic writeCtrl(input logic [3:0] v);
      pending_wr = 1; pending_val = v;
      applyStimulus();
   endtask

   int c0, o0, t0, k;
   logic [3:0] rv;

   initial begin
      p_reset2 = 1; pwdata2 = '0; count_en2 = 0; cap_ctrl_reg_sel2 = 0;
      cap_rd2 = 0; ext_wave_in2 = 0;
      rst_req = 1;
      runCycles(3);
      checking_on = 1;
      rst_req = 0;
      runCycles(2);
      #1;
      checkOutput("reset_state",
         {cap_ctrl_reg_out2, cap_valid2, capture_intr2, overrun_intr2, timeout_intr2,
          period_reg_out2, active_reg_out2}, {4'b0001, 4'b0000, 32'd0});

      // T1: continuous, rising start, 100/30
      wave_mode = 1; period_len = 100; high_len = 30; wcnt = 0;
      writeCtrl(4'b0000);
      runCycles(600); #1;
      checkOutput("t1_period", 40'(period_reg_out2), 40'd100);
      checkOutput("t1_active", 40'(active_reg_out2), 40'd30);

      // T2: falling start, low phase active
      writeCtrl(4'b0010);
      runCycles(500); #1;
      checkOutput("t2_period", 40'(period_reg_out2), 40'd100);
      checkOutput("t2_active", 40'(active_reg_out2), 40'd70);

      // T3: tick every 4th clock, start edge aligned with a tick
      writeCtrl(4'b0000);
      en_mode = 1; period_len = 400; high_len = 120; wcnt = 0;
      runCycles(1300); #1;
      checkOutput("t3_period", 40'(period_reg_out2), 40'd100);
      checkOutput("t3_active", 40'(active_reg_out2), 40'd30);

      // T4: one-shot then restart
      en_mode = 0; period_len = 100; high_len = 30; wcnt = 0;
      writeCtrl(4'b0001);
      runCycles(5);
      c0 = cap_cnt;
      writeCtrl(4'b0100);
      runCycles(350); #1;
      checkOutput("t4_oneshot_caps", 40'(cap_cnt - c0), 40'd1);
      checkOutput("t4_first_period", 40'(period_reg_out2), 40'd99);
      c0 = cap_cnt;
      writeCtrl(4'b1100);
      runCycles(2); #1;
      checkOutput("t4_restart_clr", 40'(cap_ctrl_reg_out2), 40'b0100);
      runCycles(350); #1;
      checkOutput("t4_rearm_caps", 40'(cap_cnt - c0), 40'd1);

      // T5: overrun without reads, none with coincident reads
      writeCtrl(4'b1000);
      o0 = ovr_cnt;
      runCycles(350); #1;
      checkOutput("t5_overrun", 40'(ovr_cnt > o0), 40'd1);
      rd_mode = 2;
      o0 = ovr_cnt;
      runCycles(300); #1;
      checkOutput("t5_coincident_ovr", 40'(ovr_cnt - o0), 40'd0);
      checkOutput("t5_coincident_valid", 40'(cap_valid2), 40'd1);
      rd_mode = 0;
      for (int i = 0; i < 200 && wcnt != 50; i++) applyStimulus();
      force_rd = 1;
      runCycles(2); #1;
      checkOutput("t5_read_clears", 40'(cap_valid2), 40'd0);

      // Randomized traffic
      wave_mode = 2; en_mode = 2; rd_mode = 1;
      for (int b = 0; b < 6; b++) begin
         rv = 4'($urandom);
         if ($urandom_range(0, 4) != 0) rv[0] = 1'b0;
         writeCtrl(rv);
         runCycles(500);
      end

      // T6: timeout after a single start edge, then reset mid-measure
      wave_mode = 0; en_mode = 0; rd_mode = 0; ext_wave_in2 = 0;
      runCycles(10);
      writeCtrl(4'b1000);
      runCycles(10);
      ext_wave_in2 = 1;
      k = pe + 1;
      t0 = to_cnt;
      runCycles(65560); #1;
      checkOutput("t6_timeout_cnt", 40'(to_cnt - t0), 40'd1);
      checkOutput("t6_timeout_edge", 40'(last_to_pe), 40'(k + SYNC + 65536));
      ext_wave_in2 = 0;
      runCycles(10);
      ext_wave_in2 = 1;
      runCycles(50);
      rst_req = 1;
      runCycles(2); #1;
      checkOutput("t6_reset_mid",
         {cap_ctrl_reg_out2, cap_valid2, capture_intr2, overrun_intr2, timeout_intr2,
          period_reg_out2, active_reg_out2}, {4'b0001, 4'b0000, 32'd0});
      rst_req = 0;
      runCycles(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
